// File: rtl/mlp_pkg.sv
// mlp_pkg: shared MLP definitions.
//   argmax_state_t : state encoding of the mlp_argmax scan controller.
//   clog2_min1     : address/index width helper that never returns 0, so
//                    single-entry memories still get a 1-bit address.
package mlp_pkg;

   typedef enum logic [2:0] {
      AM_IDLE,
      AM_READ,
      AM_LATCH,
      AM_SCAN,
      AM_OUT
   } argmax_state_t;

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mlp_argmax.sv
// mlp_argmax: classifier back end. Scans the final layer's output BRAM
// (VEC signed logits per word) and reports the index and value of the
// largest logit over a valid/ready handshake. Ties keep the lowest index.
//
// Ports:
//   clk                 sole clock
//   rst                 synchronous reset, active-low
//   start               begin a scan (sampled only in IDLE)
//   busy                high in every state except IDLE
//   rden, rdaddr        BRAM read port (rdaddr holds outside READ)
//   rdq                 BRAM read data, valid one cycle after address
//   out_valid/out_ready result handshake
//   class_idx, max_score argmax index and its logit
//   second_idx, margin  runner-up index and best-minus-second
//                       (only with MLP_ARGMAX_TOP2_EN defined)
//
// Build option: define MLP_ARGMAX_TOP2_EN to add runner-up tracking.
// Cycle timing is identical in both builds.
module mlp_argmax
   import mlp_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH  = 16,
   parameter  int unsigned VEC         = 16,
   parameter  int unsigned NUM_CLASSES = 10,
   localparam int unsigned WORDS       = (NUM_CLASSES + VEC - 1) / VEC,
   localparam int unsigned ADDR_WIDTH  = clog2_min1(WORDS),
   localparam int unsigned CLASS_W     = clog2_min1(NUM_CLASSES)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   output logic                      busy,
   output logic                      rden,
   output logic [ADDR_WIDTH-1:0]     rdaddr,
   input  logic [VEC*DATA_WIDTH-1:0] rdq,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CLASS_W-1:0]        class_idx,
   output logic [DATA_WIDTH-1:0]     max_score
`ifdef MLP_ARGMAX_TOP2_EN
   ,
   output logic [CLASS_W-1:0]        second_idx,
   output logic [DATA_WIDTH:0]       margin
`endif
);

   localparam int unsigned LANE_W = clog2_min1(VEC);
   localparam logic [CLASS_W-1:0] LAST_ELEM = CLASS_W'(NUM_CLASSES - 1);
   localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(VEC - 1);

   argmax_state_t state, state_nxt;

   logic [ADDR_WIDTH-1:0]     wcnt;
   logic [LANE_W-1:0]         lane;
   logic [CLASS_W-1:0]        elem;
   logic [VEC*DATA_WIDTH-1:0] shreg;
   logic [CLASS_W-1:0]        best_idx;
   logic [DATA_WIDTH-1:0]     best_val;

   logic signed [DATA_WIDTH-1:0] cur;
   logic                         first, last_elem, last_lane, gt_best;

   // lane 0 of the shift register is always the element under test
   assign cur       = $signed(shreg[DATA_WIDTH-1:0]);
   assign first     = (elem == '0);
   assign last_elem = (elem == LAST_ELEM);
   assign last_lane = (lane == LAST_LANE);
   assign gt_best   = (cur > $signed(best_val));

`ifdef MLP_ARGMAX_TOP2_EN
   logic [CLASS_W-1:0]    sec_idx;
   logic [DATA_WIDTH-1:0] sec_val;
   logic                  gt_sec;

   assign gt_sec     = (cur > $signed(sec_val));
   assign second_idx = sec_idx;
   assign margin     = {best_val[DATA_WIDTH-1], best_val} - {sec_val[DATA_WIDTH-1], sec_val};
`endif

   assign rdaddr    = wcnt;
   assign class_idx = best_idx;
   assign max_score = best_val;

   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      rden      = 1'b0;
      out_valid = 1'b0;
      case (state)
         AM_IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = AM_READ;
         end
         AM_READ: begin
            rden      = 1'b1;
            state_nxt = AM_LATCH;
         end
         AM_LATCH: state_nxt = AM_SCAN;
         AM_SCAN: begin
            // padding lanes past the last class are never visited
            if (last_elem)      state_nxt = AM_OUT;
            else if (last_lane) state_nxt = AM_READ;
         end
         AM_OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = AM_IDLE;
         end
         default: state_nxt = AM_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= AM_IDLE;
         wcnt     <= '0;
         lane     <= '0;
         elem     <= '0;
         shreg    <= '0;
         best_idx <= '0;
         best_val <= '0;
`ifdef MLP_ARGMAX_TOP2_EN
         sec_idx  <= '0;
         sec_val  <= '0;
`endif
      end else begin
         state <= state_nxt;
         case (state)
            AM_IDLE: begin
               if (start) begin
                  wcnt <= '0;
                  elem <= '0;
               end
            end
            AM_LATCH: begin
               shreg <= rdq;
               lane  <= '0;
            end
            AM_SCAN: begin
               shreg <= shreg >> DATA_WIDTH;
               lane  <= lane + 1'b1;
               elem  <= elem + 1'b1;
               if (last_lane && !last_elem) wcnt <= wcnt + 1'b1;
               if (first || gt_best) begin
                  best_idx <= elem;
                  best_val <= cur;
               end
`ifdef MLP_ARGMAX_TOP2_EN
               // element 0 seeds second as well, so a single class gives margin 0
               if (first) begin
                  sec_idx <= elem;
                  sec_val <= cur;
               end else if (gt_best) begin
                  sec_idx <= best_idx;
                  sec_val <= best_val;
               end else if (elem == CLASS_W'(1) || gt_sec) begin
                  sec_idx <= elem;
                  sec_val <= cur;
               end
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mlp_argmax.sv
module tb_mlp_argmax;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // default instance: NUM_CLASSES=10, one BRAM word
   logic         start_a, busy_a, rden_a, out_valid_a, out_ready_a;
   logic [0:0]   rdaddr_a;
   logic [255:0] rdq_a;
   logic [3:0]   class_idx_a;
   logic [15:0]  max_score_a;
   logic [255:0] mem_a [0:0];

   // second instance: NUM_CLASSES=20, two BRAM words
   logic         start_b, busy_b, rden_b, out_valid_b, out_ready_b;
   logic [0:0]   rdaddr_b;
   logic [255:0] rdq_b;
   logic [4:0]   class_idx_b;
   logic [15:0]  max_score_b;
   logic [255:0] mem_b [0:1];

`ifdef MLP_ARGMAX_TOP2_EN
   logic [3:0]  second_idx_a;
   logic [16:0] margin_a;
   logic [4:0]  second_idx_b;
   logic [16:0] margin_b;
`endif

   mlp_argmax #(.DATA_WIDTH(16), .VEC(16), .NUM_CLASSES(10)) dut (
      .clk(clk), .rst(rst), .start(start_a), .busy(busy_a),
      .rden(rden_a), .rdaddr(rdaddr_a), .rdq(rdq_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a),
      .class_idx(class_idx_a), .max_score(max_score_a)
`ifdef MLP_ARGMAX_TOP2_EN
      , .second_idx(second_idx_a), .margin(margin_a)
`endif
   );

   mlp_argmax #(.DATA_WIDTH(16), .VEC(16), .NUM_CLASSES(20)) dut20 (
      .clk(clk), .rst(rst), .start(start_b), .busy(busy_b),
      .rden(rden_b), .rdaddr(rdaddr_b), .rdq(rdq_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b),
      .class_idx(class_idx_b), .max_score(max_score_b)
`ifdef MLP_ARGMAX_TOP2_EN
      , .second_idx(second_idx_b), .margin(margin_b)
`endif
   );

   // synchronous-read BRAM models
   always @(posedge clk) if (rden_a) rdq_a <= mem_a[rdaddr_a];
   always @(posedge clk) if (rden_b) rdq_b <= mem_b[rdaddr_b];

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] pack16(input int l[16]);
      logic [255:0] w;
      w = '0;
      for (int i = 0; i < 16; i++) w[i*16 +: 16] = 16'(l[i]);
      return w;
   endfunction

   typedef struct {
      logic [255:0] word;
      int           exp_idx;
      logic [15:0]  exp_score;
      int           exp_second;
      logic [16:0]  exp_margin;
   } vec_t;

   vec_t vecs[6];

   // start pulse on dut, then wait (bounded) for out_valid
   task automatic run_a(input logic [255:0] word, output int lat, output int nrd);
      mem_a[0] = word;
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      lat = 0;
      nrd = 0;
      while (!out_valid_a && lat < 200) begin
         if (rden_a) nrd++;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic handshake_a();
      out_ready_a = 1'b1;
      @(posedge clk);
      #1;
      out_ready_a = 1'b0;
   endtask

   initial begin
      int l[16];
      int lat, nrd;
      int addrs[2];
      int na;

      rst = 1'b0;
      start_a = 1'b0; out_ready_a = 1'b0;
      start_b = 1'b0; out_ready_b = 1'b0;

      l = '{5, -3, 20, 7, 20, 0, -128, 1, 2, 3, 0, 0, 0, 0, 0, 0};
      vecs[0] = '{pack16(l), 2, 16'd20, 4, 17'd0};
      l = '{default: -32768};
      vecs[1] = '{pack16(l), 0, 16'h8000, 1, 17'd0};
      l = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1, 32767, 32767, 32767, 32767, 32767, 32767};
      vecs[2] = '{pack16(l), 0, 16'hFFFF, 1, 17'd0};
      l = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 100, 0, 0, 0, 0, 0, 0};
      vecs[3] = '{pack16(l), 9, 16'd100, 8, 17'd91};
      l = '{300, -5, 299, 0, 0, 0, 0, 0, 0, -300, 0, 0, 0, 0, 0, 0};
      vecs[4] = '{pack16(l), 0, 16'd300, 2, 17'd1};
      l = '{default: -32768};
      l[5] = 32767;
      vecs[5] = '{pack16(l), 5, 16'h7FFF, 0, 17'h0FFFF};

      repeat (3) @(posedge clk);
      #1;
      check("reset_busy",      32'(busy_a),      32'd0);
      check("reset_rden",      32'(rden_a),      32'd0);
      check("reset_rdaddr",    32'(rdaddr_a),    32'd0);
      check("reset_out_valid", 32'(out_valid_a), 32'd0);
      check("reset_class_idx", 32'(class_idx_a), 32'd0);
      check("reset_max_score", 32'(max_score_a), 32'd0);
`ifdef MLP_ARGMAX_TOP2_EN
      check("reset_second_idx", 32'(second_idx_a), 32'd0);
      check("reset_margin",     32'(margin_a),     32'd0);
`endif
      rst = 1'b1;

      for (int k = 0; k < 6; k++) begin
         run_a(vecs[k].word, lat, nrd);
         check($sformatf("v%0d_latency", k), 32'(lat), 32'd12);
         check($sformatf("v%0d_rden_count", k), 32'(nrd), 32'd1);
         check($sformatf("v%0d_class_idx", k), 32'(class_idx_a), 32'(vecs[k].exp_idx));
         check($sformatf("v%0d_max_score", k), 32'(max_score_a), 32'(vecs[k].exp_score));
`ifdef MLP_ARGMAX_TOP2_EN
         check($sformatf("v%0d_second_idx", k), 32'(second_idx_a), 32'(vecs[k].exp_second));
         check($sformatf("v%0d_margin", k), 32'(margin_a), 32'(vecs[k].exp_margin));
`endif
         handshake_a();
         check($sformatf("v%0d_idle_after_hs", k), 32'(busy_a), 32'd0);
      end

      // hold in OUT with out_ready low and start high; then back-to-back start
      run_a(vecs[0].word, lat, nrd);
      check("hold_latency", 32'(lat), 32'd12);
      start_a = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("hold%0d_out_valid", c), 32'(out_valid_a), 32'd1);
         check($sformatf("hold%0d_rden", c), 32'(rden_a), 32'd0);
         check($sformatf("hold%0d_class_idx", c), 32'(class_idx_a), 32'd2);
         check($sformatf("hold%0d_max_score", c), 32'(max_score_a), 32'd20);
      end
      start_a = 1'b0;
      handshake_a();
      check("hold_idle_after_hs", 32'(busy_a), 32'd0);
      run_a(vecs[3].word, lat, nrd);
      check("b2b_latency", 32'(lat), 32'd12);
      check("b2b_class_idx", 32'(class_idx_a), 32'd9);
      check("b2b_max_score", 32'(max_score_a), 32'd100);
      handshake_a();

      // reset asserted while scanning
      mem_a[0] = vecs[4].word;
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      check("midscan_busy_before_rst", 32'(busy_a), 32'd1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_busy",      32'(busy_a),      32'd0);
      check("midrst_out_valid", 32'(out_valid_a), 32'd0);
      check("midrst_rden",      32'(rden_a),      32'd0);
      check("midrst_rdaddr",    32'(rdaddr_a),    32'd0);
      check("midrst_class_idx", 32'(class_idx_a), 32'd0);
      check("midrst_max_score", 32'(max_score_a), 32'd0);
      rst = 1'b1;
      run_a(vecs[0].word, lat, nrd);
      check("postrst_latency",   32'(lat),         32'd12);
      check("postrst_class_idx", 32'(class_idx_a), 32'd2);
      check("postrst_max_score", 32'(max_score_a), 32'd20);
      handshake_a();

      // two-word scan: 50 at index 3, 300 at index 17, zeros elsewhere
      l = '{0, 0, 0, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      mem_b[0] = pack16(l);
      l = '{0, 300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      mem_b[1] = pack16(l);
      @(negedge clk);
      start_b = 1'b1;
      @(posedge clk);
      #1;
      start_b = 1'b0;
      lat = 0;
      na = 0;
      addrs = '{-1, -1};
      while (!out_valid_b && lat < 200) begin
         if (rden_b) begin
            if (na < 2) addrs[na] = int'(rdaddr_b);
            na++;
         end
         @(posedge clk);
         #1;
         lat++;
      end
      check("w2_latency",    32'(lat),         32'd24);
      check("w2_rden_count", 32'(na),          32'd2);
      check("w2_rdaddr0",    32'(addrs[0]),    32'd0);
      check("w2_rdaddr1",    32'(addrs[1]),    32'd1);
      check("w2_class_idx",  32'(class_idx_b), 32'd17);
      check("w2_max_score",  32'(max_score_b), 32'd300);
`ifdef MLP_ARGMAX_TOP2_EN
      check("w2_second_idx", 32'(second_idx_b), 32'd3);
      check("w2_margin",     32'(margin_b),     32'd250);
`endif
      out_ready_b = 1'b1;
      @(posedge clk);
      #1;
      out_ready_b = 1'b0;
      check("w2_idle_after_hs", 32'(busy_b), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
